// File: rtl/data_memory_access_controller_if.sv
// Request/response and RAM-side bus of the data memory access controller.
// The controller sits on the slave modport; the requester and RAM model use master.
interface data_memory_access_controller_if #(
  parameter int unsigned DATAWIDTH_BUS      = 32,
  parameter int unsigned DATAWIDTH_ADDR_MEM = 8
);
  logic                          MemCtrl_Req_RD;
  logic                          MemCtrl_Req_WR;
  logic [DATAWIDTH_BUS-1:0]      MemCtrl_Address_In;
  logic [DATAWIDTH_BUS-1:0]      MemCtrl_Data_In;
  logic [DATAWIDTH_BUS-1:0]      MemCtrl_Data_Out;
  logic                          MemCtrl_Busy;
  logic                          MemCtrl_Ack;
  logic                          MemCtrl_Err;
  logic [DATAWIDTH_ADDR_MEM-1:0] MemCtrl_Mem_Address;
  logic [DATAWIDTH_BUS-1:0]      MemCtrl_Mem_Data_Out;
  logic                          MemCtrl_Mem_RD;
  logic                          MemCtrl_Mem_WR;
  logic [DATAWIDTH_BUS-1:0]      MemCtrl_Mem_Data_In;

  modport slave (
    input  MemCtrl_Req_RD, MemCtrl_Req_WR, MemCtrl_Address_In, MemCtrl_Data_In,
           MemCtrl_Mem_Data_In,
    output MemCtrl_Data_Out, MemCtrl_Busy, MemCtrl_Ack, MemCtrl_Err,
           MemCtrl_Mem_Address, MemCtrl_Mem_Data_Out, MemCtrl_Mem_RD, MemCtrl_Mem_WR
  );

  modport master (
    output MemCtrl_Req_RD, MemCtrl_Req_WR, MemCtrl_Address_In, MemCtrl_Data_In,
           MemCtrl_Mem_Data_In,
    input  MemCtrl_Data_Out, MemCtrl_Busy, MemCtrl_Ack, MemCtrl_Err,
           MemCtrl_Mem_Address, MemCtrl_Mem_Data_Out, MemCtrl_Mem_RD, MemCtrl_Mem_WR
  );
endinterface

// File: rtl/data_memory_access_controller.sv
// Multi-cycle data RAM access controller: validates byte address, holds RAM strobes
// for WAIT_CYCLES, then issues a one-cycle Ack (with Err on rejected requests).
module data_memory_access_controller #(
  parameter int unsigned DATAWIDTH_BUS      = 32,
  parameter int unsigned DATAWIDTH_ADDR_MEM = 8,
  parameter int unsigned WAIT_CYCLES        = 2,
  parameter int unsigned DATAWIDTH_WAIT_CNT = 4
) (
  input logic                   MemCtrl_CLOCK_50,
  input logic                   MemCtrl_RESET_InLow,
  data_memory_access_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                        state_q, state_d;
  logic [DATAWIDTH_WAIT_CNT-1:0] cnt_q, cnt_d;
  logic [DATAWIDTH_ADDR_MEM-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0]      wdata_q, wdata_d;
  logic [DATAWIDTH_BUS-1:0]      dout_q, dout_d;
  logic                          mem_rd_q, mem_rd_d;
  logic                          mem_wr_q, mem_wr_d;
  logic                          ack_q, ack_d;
  logic                          err_q, err_d;
  logic                          misaligned, out_of_range;

  assign misaligned   = |bus.MemCtrl_Address_In[1:0];
  assign out_of_range = |(bus.MemCtrl_Address_In >> (DATAWIDTH_ADDR_MEM + 2));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MemCtrl_Req_RD || bus.MemCtrl_Req_WR) begin
          if ((bus.MemCtrl_Req_RD && bus.MemCtrl_Req_WR) || misaligned || out_of_range) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            addr_d   = bus.MemCtrl_Address_In[DATAWIDTH_ADDR_MEM+1:2];
            wdata_d  = bus.MemCtrl_Data_In;
            mem_rd_d = bus.MemCtrl_Req_RD;
            mem_wr_d = bus.MemCtrl_Req_WR;
            cnt_d    = DATAWIDTH_WAIT_CNT'(WAIT_CYCLES - 1);
            state_d  = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Strobes and Ack are registered, so the last strobe cycle and the Ack
        // cycle are adjacent with no gap.
        if (cnt_q == '0) begin
          if (mem_rd_q) dout_d = bus.MemCtrl_Mem_Data_In;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MemCtrl_CLOCK_50 or negedge MemCtrl_RESET_InLow) begin
    if (!MemCtrl_RESET_InLow) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.MemCtrl_Data_Out     = dout_q;
  assign bus.MemCtrl_Busy         = (state_q != IDLE);
  assign bus.MemCtrl_Ack          = ack_q;
  assign bus.MemCtrl_Err          = err_q;
  assign bus.MemCtrl_Mem_Address  = addr_q;
  assign bus.MemCtrl_Mem_Data_Out = wdata_q;
  assign bus.MemCtrl_Mem_RD       = mem_rd_q;
  assign bus.MemCtrl_Mem_WR       = mem_wr_q;

endmodule

// File: tb/tb_data_memory_access_controller.sv
// Directed bench for data_memory_access_controller: WAIT_CYCLES=2 and WAIT_CYCLES=1
// instances, RAM models, and a scoreboard of expected Ack/Err/Data_Out per request.
module tb_data_memory_access_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_access_controller_if #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR_MEM(8)) if0 ();
  data_memory_access_controller_if #(.DATAWIDTH_BUS(32), .DATAWIDTH_ADDR_MEM(8)) if1 ();

  data_memory_access_controller #(
    .DATAWIDTH_BUS(32), .DATAWIDTH_ADDR_MEM(8), .WAIT_CYCLES(2), .DATAWIDTH_WAIT_CNT(4)
  ) dut0 (.MemCtrl_CLOCK_50(clk), .MemCtrl_RESET_InLow(rst_n), .bus(if0));

  data_memory_access_controller #(
    .DATAWIDTH_BUS(32), .DATAWIDTH_ADDR_MEM(8), .WAIT_CYCLES(1), .DATAWIDTH_WAIT_CNT(4)
  ) dut1 (.MemCtrl_CLOCK_50(clk), .MemCtrl_RESET_InLow(rst_n), .bus(if1));

  logic [1:0]  req_rd = '0, req_wr = '0;
  logic [31:0] a_in [2];
  logic [31:0] d_in [2];
  logic [31:0] ram0 [256];
  logic [31:0] ram1 [256];
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_dout [2];

  assign if0.MemCtrl_Req_RD = req_rd[0];
  assign if0.MemCtrl_Req_WR = req_wr[0];
  assign if0.MemCtrl_Address_In = a_in[0];
  assign if0.MemCtrl_Data_In = d_in[0];
  assign if0.MemCtrl_Mem_Data_In = ram0[if0.MemCtrl_Mem_Address];
  assign if1.MemCtrl_Req_RD = req_rd[1];
  assign if1.MemCtrl_Req_WR = req_wr[1];
  assign if1.MemCtrl_Address_In = a_in[1];
  assign if1.MemCtrl_Data_In = d_in[1];
  assign if1.MemCtrl_Mem_Data_In = ram1[if1.MemCtrl_Mem_Address];

  always @(posedge clk) begin
    if (if0.MemCtrl_Mem_WR) ram0[if0.MemCtrl_Mem_Address] <= if0.MemCtrl_Mem_Data_Out;
    if (if1.MemCtrl_Mem_WR) ram1[if1.MemCtrl_Mem_Address] <= if1.MemCtrl_Mem_Data_Out;
  end

  logic [1:0]  o_ack, o_err, o_busy, o_rd, o_wr;
  logic [31:0] o_dout [2];
  logic [31:0] o_mdata [2];
  logic [7:0]  o_maddr [2];
  assign o_ack  = {if1.MemCtrl_Ack,    if0.MemCtrl_Ack};
  assign o_err  = {if1.MemCtrl_Err,    if0.MemCtrl_Err};
  assign o_busy = {if1.MemCtrl_Busy,   if0.MemCtrl_Busy};
  assign o_rd   = {if1.MemCtrl_Mem_RD, if0.MemCtrl_Mem_RD};
  assign o_wr   = {if1.MemCtrl_Mem_WR, if0.MemCtrl_Mem_WR};
  assign o_dout[0]  = if0.MemCtrl_Data_Out;
  assign o_dout[1]  = if1.MemCtrl_Data_Out;
  assign o_mdata[0] = if0.MemCtrl_Mem_Data_Out;
  assign o_mdata[1] = if1.MemCtrl_Mem_Data_Out;
  assign o_maddr[0] = if0.MemCtrl_Mem_Address;
  assign o_maddr[1] = if1.MemCtrl_Mem_Address;

  int acks0 = 0;
  always @(negedge clk) if (o_ack[0] === 1'b1) acks0++;

  typedef struct {
    logic        err;
    logic [31:0] dout;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on instance w; poke pulses Req_RD again while the access is in flight.
  task automatic do_req(input string name, input int w, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data, input bit poke);
    int unsigned wc;
    bit          legal, done, both, addr_ok;
    int          lat, nrd, nwr;
    logic [7:0]  word;
    logic        got_err;
    logic [31:0] got_dout;
    exp_t        e;
    wc    = (w == 1) ? 1 : 2;
    word  = addr[9:2];
    legal = (rd ^ wr) && (addr[1:0] == 2'b00) && ((addr >> 10) == 0);
    if (legal && wr) ref_mem[w][word] = data;
    if (legal && rd) last_dout[w] = ref_mem[w][word];
    e.err  = !legal;
    e.dout = last_dout[w];
    sb.push_back(e);

    @(negedge clk);
    req_rd[w] = rd; req_wr[w] = wr; a_in[w] = addr; d_in[w] = data;
    @(posedge clk);
    done = 0; both = 0; addr_ok = 1; lat = 0; nrd = 0; nwr = 0;
    got_err = 1'bx; got_dout = 'x;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_rd[w] = poke; req_wr[w] = 1'b0; a_in[w] = 32'hFFFF_FFFF; d_in[w] = 32'h0;
      end
      if (c == 2) req_rd[w] = 1'b0;
      if (o_rd[w] === 1'b1) nrd++;
      if (o_wr[w] === 1'b1) nwr++;
      if ((o_rd[w] === 1'b1 || o_wr[w] === 1'b1) && (o_maddr[w] !== word ||
          (o_wr[w] === 1'b1 && o_mdata[w] !== data))) addr_ok = 0;
      if (o_rd[w] === 1'b1 && o_wr[w] === 1'b1) both = 1;
      if (o_ack[w] === 1'b1) begin
        lat = c; done = 1; got_err = o_err[w]; got_dout = o_dout[w];
      end
    end
    req_rd[w] = 1'b0;
    e = sb.pop_front();
    check($sformatf("%s ack_latency", name), 32'(lat), legal ? 32'(wc + 1) : 32'd1);
    check($sformatf("%s err", name), {31'b0, got_err}, {31'b0, e.err});
    check($sformatf("%s data_out", name), got_dout, e.dout);
    check($sformatf("%s rd_cycles", name), 32'(nrd), (legal && rd) ? 32'(wc) : 32'd0);
    check($sformatf("%s wr_cycles", name), 32'(nwr), (legal && wr) ? 32'(wc) : 32'd0);
    check($sformatf("%s addr_data_stable", name), {31'b0, addr_ok}, 32'd1);
    check($sformatf("%s strobe_overlap", name), {31'b0, both}, 32'd0);
    @(negedge clk);
    check($sformatf("%s ack_single", name), {31'b0, o_ack[w]}, 32'd0);
    check($sformatf("%s err_clear", name), {31'b0, o_err[w]}, 32'd0);
    @(negedge clk);
    check($sformatf("%s idle_after", name), {31'b0, o_busy[w]}, 32'd0);
  endtask

  task automatic check_zero(input string name, input int w);
    check($sformatf("%s ack", name), {31'b0, o_ack[w]}, 32'd0);
    check($sformatf("%s err", name), {31'b0, o_err[w]}, 32'd0);
    check($sformatf("%s busy", name), {31'b0, o_busy[w]}, 32'd0);
    check($sformatf("%s mem_rd", name), {31'b0, o_rd[w]}, 32'd0);
    check($sformatf("%s mem_wr", name), {31'b0, o_wr[w]}, 32'd0);
    check($sformatf("%s data_out", name), o_dout[w], 32'd0);
    check($sformatf("%s mem_addr", name), {24'b0, o_maddr[w]}, 32'd0);
    check($sformatf("%s mem_data", name), o_mdata[w], 32'd0);
  endtask

  initial begin
    int acks_before;
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 32'hA500_0000 | 32'(i);
      ram1[i] = 32'h5A00_0000 | 32'(i);
      ref_mem[0][i] = ram0[i];
      ref_mem[1][i] = ram1[i];
    end
    last_dout[0] = '0; last_dout[1] = '0;
    a_in[0] = '0; a_in[1] = '0; d_in[0] = '0; d_in[1] = '0;

    #12;
    check_zero("reset0", 0);
    check_zero("reset1", 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_req("wr_10",      0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_req("wr_10_real", 0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_req("rd_10",      0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
    do_req("rd_13_misal",0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b0);
    do_req("rd_3fc",     0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0);
    do_req("rd_400",     0, 1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b0);
    do_req("rd_hi_oor",  0, 1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b0);
    do_req("rd_wr_both", 0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0);
    do_req("wr_3fc",     0, 1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0);
    do_req("rd_3fc_b",   0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0);
    do_req("rd_busy_poke",0,1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
    do_req("rd_20_poke", 0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b1);

    // Abort a read mid-access with an asynchronous reset.
    acks_before = acks0;
    @(negedge clk);
    req_rd[0] = 1'b1; a_in[0] = 32'h0000_0010;
    @(posedge clk);
    #2;
    req_rd[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("abort0", 0);
    last_dout[0] = '0; last_dout[1] = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort no_ack", 32'(acks0 - acks_before), 32'd0);
    check("abort idle", {31'b0, o_busy[0]}, 32'd0);
    do_req("rd_10_post", 0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);

    do_req("w1_wr_8",    1, 1'b0, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 1'b0);
    do_req("w1_rd_8",    1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0);
    do_req("w1_rd_misal",1, 1'b1, 1'b0, 32'h0000_0009, 32'h0,         1'b0);
    do_req("w1_rd_3fc",  1, 1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
